// File: rtl/sdram_write_feeder_pkg.sv
// Shared constants and FSM encoding for the SDRAM write feeder.
package sdram_write_feeder_pkg;

  localparam int DSIZE_DEF  = 32;
  localparam int ASIZE_DEF  = 21;
  localparam int BURST_DEF  = 256;
  localparam int BUF_AW_DEF = 9;

  localparam int BURST_MIN = 1;
  localparam int BURST_MAX = 256;
  localparam int LEN_W     = 24;

  typedef enum logic [2:0] {
    ST_SYNC = 3'd0,
    ST_FILL = 3'd1,
    ST_LOAD = 3'd2,
    ST_ARM  = 3'd3,
    ST_XFER = 3'd4
  } wf_state_t;

  function automatic int clamp_burst(input int n);
    if (n > BURST_MAX) return BURST_MAX;
    if (n < BURST_MIN) return BURST_MIN;
    return n;
  endfunction

endpackage

// File: rtl/sdram_wfeed_fifo.sv
// Synchronous first-word-fall-through buffer with level output.
module sdram_wfeed_fifo #(
  parameter int W  = 33,
  parameter int AW = 9
) (
  input  logic         REF_CLK,
  input  logic         RESET_N,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full,
  output logic [AW:0]  level
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [W-1:0]  last_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_FULL);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Once drained, keep presenting the last word handed out.
  assign rdata = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge REF_CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge REF_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sdram_write_feeder.sv
// Write-side feeder: buffers a framed word stream and arms the
// SDRAM controller one fixed-length burst at a time.
module sdram_write_feeder
  import sdram_write_feeder_pkg::*;
#(
  parameter int DSIZE     = DSIZE_DEF,
  parameter int ASIZE     = ASIZE_DEF,
  parameter int BURST_LEN = BURST_DEF,
  parameter int BUF_AW    = BUF_AW_DEF
) (
  input  logic              REF_CLK,
  input  logic              RESET_N,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DSIZE-1:0]  s_data,
  input  logic              s_sof,
  input  logic [ASIZE-1:0]  cfg_base,
  input  logic [ASIZE-1:0]  cfg_top,
  input  logic              cfg_err_clr,
  output logic [DSIZE-1:0]  WR_DATA,
  input  logic              WR_REQ,
  input  logic              WR_DONE,
  output logic [LEN_W-1:0]  WR_LENGTH,
  output logic              WR_LOAD,
  output logic [ASIZE-1:0]  WR_MIN_ADDR,
  output logic [ASIZE-1:0]  WR_MAX_ADDR,
  output logic [BUF_AW:0]   buf_level,
  output logic              err_underflow,
  output logic              err_misalign
);

  localparam int BL = clamp_burst(BURST_LEN);
  localparam int CW = $clog2(BL + 1);
  localparam logic [CW-1:0]    CNT_TOP = CW'(BL);
  localparam logic [BUF_AW:0]  LVL_ARM = (BUF_AW+1)'(BL);
  localparam logic [LEN_W-1:0] LEN_VAL = LEN_W'(BL);

  wf_state_t      state_q;
  wf_state_t      state_d;
  logic [DSIZE:0] head;
  logic           empty;
  logic           full;
  logic           push;
  logic           pop;
  logic           head_tag;
  logic           head_svc_q;
  logic           in_burst;
  logic           cnt_full;
  logic           enter_load;
  logic           enter_arm;
  logic           uf_set;
  logic           mis_set;
  logic [CW-1:0]  pop_cnt_q;

  // While hunting for a frame start only the sof word is kept.
  assign push = (state_q == ST_SYNC) ? (s_valid & s_sof)
                                     : (s_valid & ~full);
  assign pop  = WR_REQ & ~empty;

  sdram_wfeed_fifo #(
    .W  (DSIZE + 1),
    .AW (BUF_AW)
  ) u_fifo (
    .REF_CLK (REF_CLK),
    .RESET_N (RESET_N),
    .push    (push),
    .wdata   ({s_sof, s_data}),
    .pop     (pop),
    .rdata   (head),
    .empty   (empty),
    .full    (full),
    .level   (buf_level)
  );

  assign WR_DATA    = head[DSIZE-1:0];
  assign head_tag   = head[DSIZE] & ~empty;
  assign in_burst   = (state_q == ST_ARM) | (state_q == ST_XFER);
  assign cnt_full   = (pop_cnt_q == CNT_TOP);
  assign enter_load = (state_q == ST_FILL) & (state_d == ST_LOAD);
  assign enter_arm  = (state_q == ST_FILL) & (state_d == ST_ARM);

  assign uf_set  = WR_REQ & (empty | (in_burst & cnt_full));
  assign mis_set = pop & head[DSIZE] & in_burst
                 & (pop_cnt_q != '0);

  always_ff @(posedge REF_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_SYNC: begin
        if (s_valid & s_sof) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (head_tag & ~head_svc_q) state_d = ST_LOAD;
        else if (buf_level >= LVL_ARM) state_d = ST_ARM;
      end
      ST_LOAD: state_d = ST_FILL;
      ST_ARM: begin
        if (WR_REQ) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (WR_DONE) state_d = ST_FILL;
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_comb begin
    WR_LOAD = 1'b0;
    s_ready = ~full;
    unique case (1'b1)
      (state_q == ST_SYNC): s_ready = 1'b1;
      (state_q == ST_LOAD): WR_LOAD = 1'b1;
      default: ;
    endcase
  end

  // Addresses are latched on entry so they are stable under WR_LOAD.
  always_ff @(posedge REF_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      WR_LENGTH   <= '0;
      pop_cnt_q   <= '0;
      head_svc_q  <= 1'b0;
      WR_MIN_ADDR <= '0;
      WR_MAX_ADDR <= '0;
    end else begin
      if (enter_arm) begin
        WR_LENGTH <= LEN_VAL;
      end else if ((state_q == ST_XFER) && WR_DONE) begin
        WR_LENGTH <= '0;
      end
      if (enter_arm) begin
        pop_cnt_q <= '0;
      end else if (in_burst && WR_REQ && !cnt_full) begin
        pop_cnt_q <= pop_cnt_q + 1'b1;
      end
      if (pop) begin
        head_svc_q <= 1'b0;
      end else if (state_q == ST_LOAD) begin
        head_svc_q <= 1'b1;
      end
      if (enter_load) begin
        WR_MIN_ADDR <= cfg_base;
        WR_MAX_ADDR <= cfg_top;
      end
    end
  end

  always_ff @(posedge REF_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      err_underflow <= 1'b0;
      err_misalign  <= 1'b0;
    end else begin
      err_underflow <= uf_set | (err_underflow & ~cfg_err_clr);
      err_misalign  <= mis_set | (err_misalign & ~cfg_err_clr);
    end
  end

endmodule

// File: tb/tb_sdram_write_feeder.sv
// Bench for sdram_write_feeder: directed step table, corner
// sequences and a randomized producer/controller run.
module tb_sdram_write_feeder;

  localparam int DW = 32;
  localparam int AW = 21;
  localparam int BL = 256;
  localparam int BAW = 9;

  logic          REF_CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_sof = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [AW-1:0] cfg_top = '0;
  logic          cfg_err_clr = 1'b0;
  logic [DW-1:0] WR_DATA;
  logic          WR_REQ = 1'b0;
  logic          WR_DONE = 1'b0;
  logic [23:0]   WR_LENGTH;
  logic          WR_LOAD;
  logic [AW-1:0] WR_MIN_ADDR;
  logic [AW-1:0] WR_MAX_ADDR;
  logic [BAW:0]  buf_level;
  logic          err_underflow;
  logic          err_misalign;

  sdram_write_feeder dut (
    .REF_CLK       (REF_CLK),
    .RESET_N       (RESET_N),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_sof         (s_sof),
    .cfg_base      (cfg_base),
    .cfg_top       (cfg_top),
    .cfg_err_clr   (cfg_err_clr),
    .WR_DATA       (WR_DATA),
    .WR_REQ        (WR_REQ),
    .WR_DONE       (WR_DONE),
    .WR_LENGTH     (WR_LENGTH),
    .WR_LOAD       (WR_LOAD),
    .WR_MIN_ADDR   (WR_MIN_ADDR),
    .WR_MAX_ADDR   (WR_MAX_ADDR),
    .buf_level     (buf_level),
    .err_underflow (err_underflow),
    .err_misalign  (err_misalign)
  );

  always #5 REF_CLK = ~REF_CLK;

  int total = 0;
  int bad = 0;

  // Reference model: accepted words in order, {tag, data}.
  logic [DW:0]   exp_q[$];
  bit            synced = 0;
  bit            exp_uf = 0;
  bit            exp_mis = 0;
  logic [DW-1:0] last_word = '0;

  int load_cnt = 0;
  bit both_seen = 0;

  always @(posedge REF_CLK or negedge RESET_N) begin
    if (!RESET_N) load_cnt <= 0;
    else if (WR_LOAD) load_cnt <= load_cnt + 1;
  end

  always @(negedge REF_CLK) begin
    if (RESET_N && WR_LOAD && (WR_LENGTH != 0)) both_seen <= 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    s_valid = 1'b0;
    s_sof = 1'b0;
    WR_REQ = 1'b0;
    WR_DONE = 1'b0;
    cfg_err_clr = 1'b0;
    exp_q.delete();
    synced = 0;
    exp_uf = 0;
    exp_mis = 0;
    repeat (2) @(posedge REF_CLK);
    @(negedge REF_CLK);
    chk("rst_len", WR_LENGTH, 0);
    chk("rst_load", WR_LOAD, 0);
    chk("rst_level", buf_level, 0);
    chk("rst_ready", s_ready, 1);
    chk("rst_data", WR_DATA, 0);
    chk("rst_min", WR_MIN_ADDR, 0);
    chk("rst_max", WR_MAX_ADDR, 0);
    chk("rst_errs", {err_underflow, err_misalign}, 0);
    RESET_N = 1'b1;
    @(posedge REF_CLK);
    #1;
  endtask

  // Called and returns one step after a rising edge.
  task automatic push_word(input logic [DW-1:0] d, input bit sof);
    bit ok = 0;
    s_valid = 1'b1;
    s_data = d;
    s_sof = sof;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge REF_CLK);
      if (s_ready) begin
        ok = 1;
        if (synced || sof) begin
          synced = 1;
          exp_q.push_back({sof, d});
        end
      end
      @(posedge REF_CLK);
      #1;
    end
    s_valid = 1'b0;
    s_sof = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL push_timeout: s_ready never high");
    end
  endtask

  // Controller model: wait for a request, pop nreq words, WR_DONE.
  task automatic do_burst(input int nreq, input bit gaps);
    bit got = 0;
    logic [DW:0] e;
    logic [23:0] len = '0;
    for (int i = 0; i < 5000 && !got; i++) begin
      @(negedge REF_CLK);
      if (WR_LENGTH != 0) begin
        got = 1;
        len = WR_LENGTH;
      end
      @(posedge REF_CLK);
      #1;
    end
    chk("arm_len", len, BL);
    if (!got) return;
    for (int k = 0; k < nreq; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge REF_CLK);
          #1;
        end
      end
      WR_REQ = 1'b1;
      @(negedge REF_CLK);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_data", WR_DATA, e[DW-1:0]);
        last_word = e[DW-1:0];
        if (e[DW] && k != 0) exp_mis = 1;
      end else begin
        exp_uf = 1;
      end
      if (k >= BL) exp_uf = 1;
      @(posedge REF_CLK);
      #1;
      WR_REQ = 1'b0;
    end
    WR_DONE = 1'b1;
    @(posedge REF_CLK);
    #1;
    WR_DONE = 1'b0;
    @(negedge REF_CLK);
    chk("len_after_done", WR_LENGTH, 0);
    @(posedge REF_CLK);
    #1;
  endtask

  typedef struct {
    bit          rst;
    int          junk;
    int          words;
    int          words2;
    logic [20:0] base;
    logic [20:0] top;
    int          bursts;
    int          nreq;
    int          loads;
    bit          uf;
    bit          mis;
  } step_t;

  step_t steps[5];
  int    lc0;
  int    nb[6];
  int    nbt;
  logic [AW-1:0] rb;
  logic [AW-1:0] rt;

  initial begin
    #(4000000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    steps[0] = '{1, 3, 256, 0, 21'h000100, 21'h01ffff,
                 1, 256, 1, 0, 0};
    steps[1] = '{0, 0, 512, 0, 21'h000100, 21'h01ffff,
                 2, 256, 1, 0, 0};
    steps[2] = '{0, 0, 256, 0, 21'h040000, 21'h05ffff,
                 1, 256, 1, 0, 0};
    steps[3] = '{0, 0, 256, 0, 21'h000200, 21'h0003ff,
                 1, 257, 1, 1, 0};
    steps[4] = '{0, 0, 300, 212, 21'h010000, 21'h01ffff,
                 2, 256, 1, 0, 1};

    for (int s = 0; s < 5; s++) begin
      if (steps[s].rst) do_reset();
      cfg_base = steps[s].base;
      cfg_top = steps[s].top;
      lc0 = load_cnt;
      for (int j = 0; j < steps[s].junk; j++)
        push_word($urandom, 1'b0);
      for (int j = 0; j < steps[s].words; j++)
        push_word($urandom, j == 0);
      for (int j = 0; j < steps[s].words2; j++)
        push_word($urandom, j == 0);
      for (int b = 0; b < steps[s].bursts; b++)
        do_burst(steps[s].nreq, 1'b0);
      repeat (2) @(posedge REF_CLK);
      @(negedge REF_CLK);
      chk($sformatf("s%0d_loads", s), load_cnt - lc0, steps[s].loads);
      chk($sformatf("s%0d_min", s), WR_MIN_ADDR, steps[s].base);
      chk($sformatf("s%0d_max", s), WR_MAX_ADDR, steps[s].top);
      chk($sformatf("s%0d_uf", s), err_underflow, steps[s].uf);
      chk($sformatf("s%0d_mis", s), err_misalign, steps[s].mis);
      chk($sformatf("s%0d_lvl", s), buf_level, 0);
      chk($sformatf("s%0d_hold", s), WR_DATA, last_word);
      @(posedge REF_CLK);
      #1;
      cfg_err_clr = 1'b1;
      @(posedge REF_CLK);
      #1;
      cfg_err_clr = 1'b0;
      exp_uf = 0;
      exp_mis = 0;
      @(negedge REF_CLK);
      chk($sformatf("s%0d_clr", s), {err_underflow, err_misalign}, 0);
      @(posedge REF_CLK);
      #1;
    end

    // Stall below a burst, arm timing, then a completely full buffer.
    do_reset();
    push_word($urandom, 1'b1);
    for (int j = 0; j < 99; j++) push_word($urandom, 1'b0);
    repeat (20) @(posedge REF_CLK);
    @(negedge REF_CLK);
    chk("stall_len", WR_LENGTH, 0);
    chk("stall_lvl", buf_level, 100);
    @(posedge REF_CLK);
    #1;
    for (int j = 0; j < 156; j++) push_word($urandom, 1'b0);
    @(negedge REF_CLK);
    chk("lvl_256", buf_level, 256);
    chk("len_pre_arm", WR_LENGTH, 0);
    @(negedge REF_CLK);
    chk("len_armed", WR_LENGTH, BL);
    @(posedge REF_CLK);
    #1;
    for (int j = 0; j < 256; j++) push_word($urandom, 1'b0);
    @(negedge REF_CLK);
    chk("full_ready", s_ready, 0);
    chk("full_lvl", buf_level, 512);
    s_valid = 1'b1;
    s_data = 32'hdeadbeef;
    repeat (4) @(posedge REF_CLK);
    #1;
    s_valid = 1'b0;
    @(negedge REF_CLK);
    chk("full_hold_lvl", buf_level, 512);
    @(posedge REF_CLK);
    #1;
    do_burst(BL, 1'b0);
    do_burst(BL, 1'b0);
    @(negedge REF_CLK);
    chk("drain_lvl", buf_level, 0);
    chk("drain_errs", {err_underflow, err_misalign}, 0);
    @(posedge REF_CLK);
    #1;

    // Reset asserted in the middle of a burst.
    push_word($urandom, 1'b1);
    for (int j = 0; j < 299; j++) push_word($urandom, 1'b0);
    @(negedge REF_CLK);
    chk("mid_len", WR_LENGTH, BL);
    @(posedge REF_CLK);
    #1;
    for (int j = 0; j < 10; j++) begin
      WR_REQ = 1'b1;
      @(posedge REF_CLK);
      #1;
    end
    WR_REQ = 1'b0;
    #2;
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_len", WR_LENGTH, 0);
    chk("mid_rst_lvl", buf_level, 0);
    chk("mid_rst_data", WR_DATA, 0);
    do_reset();

    // Random frames against the queue model.
    rb = AW'($urandom);
    rt = AW'($urandom);
    cfg_base = rb;
    cfg_top = rt;
    lc0 = load_cnt;
    nbt = 0;
    for (int f = 0; f < 6; f++) begin
      nb[f] = $urandom_range(1, 2);
      nbt += nb[f];
    end
    fork
      begin
        repeat ($urandom_range(1, 4)) push_word($urandom, 1'b0);
        for (int f = 0; f < 6; f++) begin
          for (int j = 0; j < nb[f] * BL; j++) begin
            if ($urandom_range(0, 3) == 0) begin
              @(posedge REF_CLK);
              #1;
            end
            push_word($urandom, j == 0);
          end
        end
      end
      begin
        for (int b = 0; b < nbt; b++) do_burst(BL, 1'b1);
      end
    join
    repeat (2) @(posedge REF_CLK);
    @(negedge REF_CLK);
    chk("rnd_loads", load_cnt - lc0, 6);
    chk("rnd_uf", err_underflow, exp_uf);
    chk("rnd_mis", err_misalign, exp_mis);
    chk("rnd_lvl", buf_level, 0);
    chk("rnd_min", WR_MIN_ADDR, rb);
    chk("rnd_max", WR_MAX_ADDR, rt);
    chk("rnd_model_left", exp_q.size(), 0);
    chk("load_len_overlap", both_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
